// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction-memory address drive and a 2-entry
// {pc, instr} FIFO that feeds decode over a valid/ready handshake. Execute can
// redirect the fetch stream; a misaligned target halts fetching until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_misaligned,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;

  // Two-slot circular buffer; head points at the oldest entry.
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        head;
  logic [1:0]  count;
  logic        tail;

  logic        pop;
  logic        push;
  logic        redirect_act;
  logic        redirect_bad;

  // With count in {0,1,2}, head+count modulo 2 is the next free slot; when the
  // buffer is full this is the slot being vacated by a same-cycle pop.
  assign tail         = head ^ count[0];

  assign if_valid     = (count != 2'd0);
  assign pop          = if_valid && if_ready;
  assign redirect_act = redirect_valid && (state != HALT);
  assign redirect_bad = redirect_act && (redirect_target[1:0] != 2'b00);
  assign push         = (state == RUN) && !redirect_valid &&
                        ((count != 2'd2) || pop);

  assign imem_addr    = fetch_pc;
  assign if_pc        = buf_pc[head];
  assign if_instr     = buf_instr[head];
  assign if_pc_plus4  = buf_pc[head] + 32'd4;

  // Control FSM, program counter, occupancy and retirement counter.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= BOOT;
      fetch_pc         <= RESET_PC;
      count            <= 2'd0;
      head             <= 1'b0;
      fetch_misaligned <= 1'b0;
      retired_count    <= 32'd0;
    end else begin
      // A handshake completes even in a redirect cycle; HALT never has one.
      if (pop) begin
        retired_count <= retired_count + 32'd1;
      end

      if (redirect_act) begin
        count <= 2'd0;
        head  <= 1'b0;
        if (redirect_bad) begin
          fetch_misaligned <= 1'b1;
          state            <= HALT;
        end else begin
          fetch_pc <= redirect_target;
          state    <= RUN;
        end
      end else begin
        if (state == BOOT) begin
          state <= RUN;
        end
        if (push) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        count <= count + 2'(push) - 2'(pop);
        head  <= head ^ pop;
      end
    end
  end

  // Buffer payload write at the tail slot.
  // NOTE: the payload array is not reset; count gates validity, so stale
  // contents are never observed and the storage needs no reset wiring.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      buf_pc[tail]    <= fetch_pc;
      buf_instr[tail] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by randomized traffic, all checked
// against a queue-based behavioural model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fetch_misaligned;
  logic [31:0] retired_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr        (imem_addr),
    .imem_instr       (imem_instr),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .if_pc_plus4      (if_pc_plus4),
    .fetch_misaligned (fetch_misaligned),
    .retired_count    (retired_count)
  );

  // Instruction memory stand-in: fixed words at the addresses the directed
  // tests name, an address-derived pattern everywhere else.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0010_0093;
      32'h0000_0004: mem_word = 32'h0020_0113;
      32'h0000_0008: mem_word = 32'h0020_81b3;
      32'h0000_0064: mem_word = 32'h0038_0813;
      default:       mem_word = {a[15:0] ^ 16'h5a5a, a[31:16]} ^ 32'h0000_0013;
    endcase
  endfunction

  assign imem_instr = mem_word(imem_addr);

  // Behavioural model: mode 0 = booting, 1 = running, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_mis;
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];

  task automatic model_step(input logic rst, input logic rdv,
                            input logic [31:0] tgt, input logic rdy);
    logic pop;
    if (!rst) begin
      m_mode = 0;
      m_pc   = 32'h0;
      m_ret  = 32'h0;
      m_mis  = 1'b0;
      q_pc.delete();
      q_in.delete();
      return;
    end
    if (m_mode == 2) return;
    pop = (q_pc.size() > 0) && rdy;
    if (pop) begin
      m_ret = m_ret + 32'd1;
      void'(q_pc.pop_front());
      void'(q_in.pop_front());
    end
    if (rdv) begin
      q_pc.delete();
      q_in.delete();
      if (tgt[1:0] != 2'b00) begin
        m_mis  = 1'b1;
        m_mode = 2;
      end else begin
        m_pc   = tgt;
        m_mode = 1;
      end
    end else begin
      if (m_mode == 1 && q_pc.size() < 2) begin
        q_pc.push_back(m_pc);
        q_in.push_back(mem_word(m_pc));
        m_pc = m_pc + 32'd4;
      end
      m_mode = 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %08h expected %08h", name, obs, exp);
    end
  endtask

  task automatic check_all();
    check("if_valid", 32'(if_valid), 32'(q_pc.size() > 0));
    if (q_pc.size() > 0) begin
      check("if_pc", if_pc, q_pc[0]);
      check("if_instr", if_instr, q_in[0]);
      check("if_pc_plus4", if_pc_plus4, q_pc[0] + 32'd4);
    end
    check("imem_addr", imem_addr, m_pc);
    check("fetch_misaligned", 32'(fetch_misaligned), 32'(m_mis));
    check("retired_count", retired_count, m_ret);
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input logic rst, input logic rdv,
                      input logic [31:0] tgt, input logic rdy);
    rst_n           = rst;
    redirect_valid  = rdv;
    redirect_target = tgt;
    if_ready        = rdy;
    model_step(rst, rdv, tgt, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic        r_rst;
    logic        r_rdv;
    logic [31:0] r_tgt;
    logic        r_rdy;

    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    if_ready        = 1'b0;

    // Reset state.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_retired", retired_count, 32'd0);

    // Release with decode always ready.
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("e0_valid", 32'(if_valid), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("e1_pc", if_pc, 32'h0);
    check("e1_instr", if_instr, 32'h0010_0093);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("e2_pc", if_pc, 32'h4);
    check("e2_instr", if_instr, 32'h0020_0113);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("e3_pc", if_pc, 32'h8);
    check("e3_instr", if_instr, 32'h0020_81b3);
    check("e3_retired", retired_count, 32'd2);

    // Backpressure from reset for 5 cycles.
    step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    check("bp_addr", imem_addr, 32'h8);
    check("bp_head", if_pc, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("bp_rel1", if_pc, 32'h4);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("bp_rel2", if_pc, 32'h8);

    // Redirect to 0x64 with the buffer full and a pop in flight.
    step(1'b1, 1'b1, 32'h64, 1'b1);
    check("rd_bubble", 32'(if_valid), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("rd_pc", if_pc, 32'h64);
    check("rd_instr", if_instr, 32'h0038_0813);
    check("rd_plus4", if_pc_plus4, 32'h68);

    // Wrap at the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_plus4", if_pc_plus4, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("wrap_next", if_pc, 32'h0);

    // Reset with two entries buffered.
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("mid_rst_valid", 32'(if_valid), 32'd0);
    check("mid_rst_retired", retired_count, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("mid_rst_head", if_pc, 32'h0);

    // Misaligned redirect halts; later redirects are ignored.
    step(1'b1, 1'b1, 32'h66, 1'b1);
    check("mis_flag", 32'(fetch_misaligned), 32'd1);
    step(1'b1, 1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    check("mis_valid", 32'(if_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("mis_cleared", 32'(fetch_misaligned), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("mis_restart", if_pc, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(63) != 0);
      r_rdv = ($urandom_range(7) == 0);
      r_rdy = ($urandom_range(3) != 0);
      case ($urandom_range(3))
        0:       r_tgt = $urandom & 32'hFFFF_FFFC;
        1:       r_tgt = 32'hFFFF_FFF8 | (32'($urandom_range(1)) << 2);
        2:       r_tgt = 32'($urandom_range(63)) << 2;
        default: r_tgt = 32'h0000_0064;
      endcase
      if ($urandom_range(15) == 0) r_tgt = r_tgt | 32'($urandom_range(3, 1));
      step(r_rst, r_rdv, r_tgt, r_rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
